// File: rtl/stream_fifo_regs_1clk.sv
// stream_fifo_regs_1clk
//
// Single-clock streaming FIFO built from a flip-flop register array. The head
// word is driven combinationally from the storage, so there is no read latency.
// There is no fall-through path: a word pushed at edge N first appears at the
// output after edge N.
//
// Ports:
//   i_clk         clock; all state updates happen on the rising edge
//   i_rst         synchronous, active-high reset; overrides push and pop
//   i_din_valid   producer has a word on i_din_data
//   o_din_ready   FIFO can accept a word (not full)
//   i_din_data    write data
//   o_dout_valid  FIFO holds at least one word (not empty)
//   i_dout_ready  consumer takes the head word this cycle
//   o_dout_data   head word (oldest entry); don't-care while empty
//   o_used        current occupancy, 0..Depth
module stream_fifo_regs_1clk #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_din_valid,
  output logic                       o_din_ready,
  input  logic [Width-1:0]           i_din_data,
  output logic                       o_dout_valid,
  input  logic                       i_dout_ready,
  output logic [Width-1:0]           o_dout_data,
  output logic [$clog2(Depth+1)-1:0] o_used
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW-1:0]  r_wr_ptr;
  logic [CntW-1:0]  r_count;

  logic             w_push;
  logic             w_pop;
  logic [PtrW-1:0]  w_rd_ptr_nxt;
  logic [PtrW-1:0]  w_wr_ptr_nxt;
  logic [CntW-1:0]  w_count_nxt;

  // Flags come only from the registered count, which keeps din_ready
  // independent of dout_ready and dout_valid independent of din_valid.
  assign o_din_ready  = (r_count != FullCnt);
  assign o_dout_valid = (r_count != '0);
  assign o_used       = r_count;
  assign o_dout_data  = r_mem[r_rd_ptr];

  assign w_push = i_din_valid & o_din_ready;
  assign w_pop  = i_dout_ready & o_dout_valid;

  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;

    // Explicit wrap compare so non-power-of-two depths work.
    if (w_pop) begin
      w_rd_ptr_nxt = (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
    end
    if (w_push) begin
      w_wr_ptr_nxt = (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
    end

    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_mem[r_wr_ptr] <= i_din_data;
    end
  end

endmodule

// File: tb/tb_stream_fifo_regs_1clk.sv
// Bench for stream_fifo_regs_1clk: directed sequences on a Depth=4 instance and
// a randomized stall run on a Depth=3 instance checked against a queue model.
module tb_stream_fifo_regs_1clk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Depth=4 instance
  logic       a_rst, a_din_valid, a_din_ready, a_dout_valid, a_dout_ready;
  logic [7:0] a_din_data, a_dout_data;
  logic [2:0] a_used;

  // Depth=3 instance
  logic       b_rst, b_din_valid, b_din_ready, b_dout_valid, b_dout_ready;
  logic [7:0] b_din_data, b_dout_data;
  logic [1:0] b_used;

  stream_fifo_regs_1clk #(.Width(8), .Depth(4)) dut_a (
    .i_clk        (clk),
    .i_rst        (a_rst),
    .i_din_valid  (a_din_valid),
    .o_din_ready  (a_din_ready),
    .i_din_data   (a_din_data),
    .o_dout_valid (a_dout_valid),
    .i_dout_ready (a_dout_ready),
    .o_dout_data  (a_dout_data),
    .o_used       (a_used)
  );

  stream_fifo_regs_1clk #(.Width(8), .Depth(3)) dut_b (
    .i_clk        (clk),
    .i_rst        (b_rst),
    .i_din_valid  (b_din_valid),
    .o_din_ready  (b_din_ready),
    .i_din_data   (b_din_data),
    .o_dout_valid (b_dout_valid),
    .i_dout_ready (b_dout_ready),
    .o_dout_data  (b_dout_data),
    .o_used       (b_used)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land just after it, where outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_data[$];
  bit         m_push, m_pop;

  initial begin
    a_rst = 1'b1; a_din_valid = 1'b0; a_din_data = '0; a_dout_ready = 1'b0;
    b_rst = 1'b1; b_din_valid = 1'b0; b_din_data = '0; b_dout_ready = 1'b0;
    step();
    check("reset_used", 32'(a_used), 0);
    check("reset_dout_valid", 32'(a_dout_valid), 0);
    check("reset_din_ready", 32'(a_din_ready), 1);
    check("reset_b_used", 32'(b_used), 0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Fill with consumer stalled
    for (int i = 0; i < 4; i++) begin
      a_din_valid = 1'b1;
      a_din_data  = 8'(8'h11 * (i + 1));
      step();
      check("fill_used", 32'(a_used), 32'(i + 1));
    end
    check("fill_din_ready_low", 32'(a_din_ready), 0);
    a_din_data = 8'h55;
    step();
    check("fill_reject_used", 32'(a_used), 4);
    check("fill_head", 32'(a_dout_data), 32'h11);

    // Drain
    a_din_valid  = 1'b0;
    a_dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(a_dout_valid), 1);
      check("drain_data", 32'(a_dout_data), 32'(8'h11 * (i + 1)));
      step();
    end
    check("drain_valid_low", 32'(a_dout_valid), 0);
    check("drain_used", 32'(a_used), 0);

    // Streaming: push and pop every cycle; one cycle of latency, then no gaps
    for (int k = 0; k < 20; k++) begin
      a_din_valid = 1'b1;
      a_din_data  = 8'(k);
      if (k == 0) begin
        check("stream_empty_first", 32'(a_dout_valid), 0);
      end else begin
        check("stream_valid", 32'(a_dout_valid), 1);
        check("stream_data", 32'(a_dout_data), 32'(k - 1));
      end
      step();
      check("stream_used", 32'(a_used), 1);
    end
    a_din_valid = 1'b0;
    check("stream_last", 32'(a_dout_data), 32'd19);
    step();
    check("stream_end_used", 32'(a_used), 0);

    // Full plus simultaneous pop: pop happens, push rejected
    a_dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_din_valid = 1'b1;
      a_din_data  = 8'(8'hA0 + i);
      step();
    end
    check("full_used", 32'(a_used), 4);
    a_din_data   = 8'hAA;
    a_dout_ready = 1'b1;
    step();
    check("fullpop_used", 32'(a_used), 3);
    check("fullpop_din_ready", 32'(a_din_ready), 1);
    a_dout_ready = 1'b0;
    step();
    check("fullpop_push_used", 32'(a_used), 4);
    a_din_valid = 1'b0;
    exp_data = '{8'hA1, 8'hA2, 8'hA3, 8'hAA};
    a_dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fullpop_order", 32'(a_dout_data), 32'(exp_data[i]));
      step();
    end
    check("fullpop_empty", 32'(a_dout_valid), 0);
    a_dout_ready = 1'b0;

    // Reset mid-operation with a handshake pending
    a_din_valid = 1'b1;
    a_din_data  = 8'h01;
    step();
    a_din_data = 8'h02;
    step();
    check("rstmid_used_before", 32'(a_used), 2);
    a_rst      = 1'b1;
    a_din_data = 8'h77;
    step();
    a_rst       = 1'b0;
    a_din_valid = 1'b0;
    check("rstmid_used", 32'(a_used), 0);
    check("rstmid_dout_valid", 32'(a_dout_valid), 0);
    check("rstmid_din_ready", 32'(a_din_ready), 1);
    a_din_valid = 1'b1;
    a_din_data  = 8'h5A;
    step();
    a_din_valid = 1'b0;
    check("rstmid_first_out", 32'(a_dout_data), 32'h5A);
    check("rstmid_first_valid", 32'(a_dout_valid), 1);
    check("rstmid_used_after", 32'(a_used), 1);

    // Depth=3 random stall run against a queue model
    q.delete();
    for (int c = 0; c < 1000; c++) begin
      check("rand_used", 32'(b_used), 32'(q.size()));
      check("rand_used_bound", 32'(b_used <= 2'd3), 1);
      check("rand_dout_valid", 32'(b_dout_valid), 32'(q.size() != 0));
      check("rand_din_ready", 32'(b_din_ready), 32'(q.size() != 3));
      if (q.size() != 0) check("rand_data", 32'(b_dout_data), 32'(q[0]));
      b_din_valid  = ($urandom_range(99) < 60);
      b_dout_ready = ($urandom_range(99) < 40);
      b_din_data   = 8'($urandom);
      m_push = b_din_valid && (q.size() < 3);
      m_pop  = b_dout_ready && (q.size() > 0);
      step();
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(b_din_data);
    end
    b_din_valid  = 1'b0;
    b_dout_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
